// File: rtl/mac_rx_cell_slicer.sv
// MAC RX gearbox: 32 B beats in, 64 B framed cells out.
// Truncates packets longer than MAX_PKT_CELLS cells.
module mac_rx_cell_slicer #(
  parameter int unsigned MAX_PKT_CELLS = 144
) (
  input  logic         clk_mac,
  input  logic         rst_mac,
  input  logic         in_valid,
  input  logic [255:0] in_data,
  input  logic         in_last,
  input  logic [5:0]   in_bytes,
  output logic         in_ready,
  output logic         cell_valid,
  output logic         cell_sof,
  output logic         cell_eof,
  output logic [6:0]   cell_eop_len,
  output logic [511:0] cell_data,
  input  logic         cell_ready,
  output logic [31:0]  pkt_cnt,
  output logic [31:0]  cell_cnt,
  output logic [31:0]  trunc_cnt
);

  typedef enum logic [1:0] {
    LO   = 2'd0,
    HI   = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CIDX = 8'(MAX_PKT_CELLS - 1);

  state_e         state_q, state_d;
  logic           first_q, first_d;
  logic [7:0]     cidx_q, cidx_d;
  logic [255:0]   half_q, half_d;

  logic           valid_q, valid_d;
  logic           sof_q, sof_d;
  logic           eof_q, eof_d;
  logic [6:0]     len_q, len_d;
  logic [511:0]   data_q, data_d;

  logic [31:0]    pkt_q, pkt_d;
  logic [31:0]    cell_q, cell_d;
  logic [31:0]    trunc_q, trunc_d;

  logic           acc;
  logic [255:0]   beat_mask;
  logic [255:0]   last_beat;

  assign in_ready = (state_q == DROP) | ~valid_q | cell_ready;
  assign acc      = in_valid & in_ready;

  // Keep only the valid bytes of a final beat
  always_comb begin
    beat_mask = '0;
    for (int k = 0; k < 32; k++) begin
      beat_mask[8*k +: 8] = (6'(k) < in_bytes) ? 8'hFF : 8'h00;
    end
    last_beat = in_data & beat_mask;
  end

  // Gearbox FSM next state, cell slot load and counters
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    cidx_d  = cidx_q;
    half_d  = half_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    len_d   = len_q;
    data_d  = data_q;
    pkt_d   = pkt_q;
    cell_d  = cell_q;
    trunc_d = trunc_q;

    if (valid_q && cell_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      LO: begin
        if (acc && !in_last) begin
          half_d  = in_data;
          state_d = HI;
        end else if (acc) begin
          valid_d = 1'b1;
          sof_d   = first_q;
          eof_d   = 1'b1;
          len_d   = {1'b0, in_bytes};
          data_d  = {256'b0, last_beat};
          first_d = 1'b1;
          cidx_d  = '0;
          pkt_d   = pkt_q + 32'd1;
          cell_d  = cell_q + 32'd1;
        end
      end
      HI: begin
        if (acc) begin
          valid_d = 1'b1;
          sof_d   = first_q;
          first_d = 1'b0;
          cell_d  = cell_q + 32'd1;
          if (in_last) begin
            eof_d   = 1'b1;
            len_d   = 7'd32 + {1'b0, in_bytes};
            data_d  = {last_beat, half_q};
            first_d = 1'b1;
            cidx_d  = '0;
            pkt_d   = pkt_q + 32'd1;
            state_d = LO;
          end else if (cidx_q == LAST_CIDX) begin
            eof_d   = 1'b1;
            len_d   = 7'd64;
            data_d  = {in_data, half_q};
            first_d = 1'b1;
            cidx_d  = '0;
            pkt_d   = pkt_q + 32'd1;
            trunc_d = trunc_q + 32'd1;
            state_d = DROP;
          end else begin
            eof_d   = 1'b0;
            len_d   = '0;
            data_d  = {in_data, half_q};
            cidx_d  = cidx_q + 8'd1;
            state_d = LO;
          end
        end
      end
      DROP: begin
        if (acc && in_last) begin
          state_d = LO;
        end
      end
      default: begin
        state_d = LO;
      end
    endcase
  end

  // State, cell slot and counter registers
  always_ff @(posedge clk_mac) begin
    if (rst_mac) begin
      state_q <= LO;
      first_q <= 1'b1;
      cidx_q  <= '0;
      half_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
      pkt_q   <= '0;
      cell_q  <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cidx_q  <= cidx_d;
      half_q  <= half_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      len_q   <= len_d;
      data_q  <= data_d;
      pkt_q   <= pkt_d;
      cell_q  <= cell_d;
      trunc_q <= trunc_d;
    end
  end

  // Final-beat byte count must be 1..32
  always_ff @(posedge clk_mac) begin
    if (!rst_mac && acc && in_last) begin
      assert (in_bytes != 6'd0 && in_bytes <= 6'd32);
    end
  end

  assign cell_valid   = valid_q;
  assign cell_sof     = sof_q;
  assign cell_eof     = eof_q;
  assign cell_eop_len = len_q;
  assign cell_data    = data_q;
  assign pkt_cnt      = pkt_q;
  assign cell_cnt     = cell_q;
  assign trunc_cnt    = trunc_q;

endmodule
